// File: rtl/xbutton_resp_pkg.sv
// Shared constants for the switch/button responder: bus widths and the register map.
package xbutton_resp_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BUTTON_ADDR_W = 2;

  typedef enum logic [BUTTON_ADDR_W-1:0] {
    SW_LVL_ADDR   = 2'd0,
    BTN_LVL_ADDR  = 2'd1,
    BTN_EVT_ADDR  = 2'd2,
    BTN_MASK_ADDR = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/xbutton_resp_if.sv
// Decoder-to-responder register bus: select, write strobe, offset and data.
interface xbutton_resp_if;
  import xbutton_resp_pkg::*;

  logic                     sel;
  logic                     we;
  logic [BUTTON_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]        data_in;
  logic [DATA_W-1:0]        data_to_rd;

  modport master (output sel, output we, output addr, output data_in, input  data_to_rd);
  modport slave  (input  sel, input  we, input  addr, input  data_in, output data_to_rd);
endinterface

// File: rtl/xbutton_resp_xdebounce.sv
// One-bit two-flop synchroniser followed by a counter-based debouncer.
module xdebounce #(
  parameter int unsigned DEB_W   = 16,
  parameter int unsigned DEB_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

  logic [1:0]       r_sync;
  logic [DEB_W-1:0] r_cnt;
  logic             r_stable;

  // Any return to the stable level before the count completes restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], in};
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign out = r_stable;

endmodule

// File: rtl/xbutton_resp.sv
// Switch/button bus responder: debounced levels, sticky press events, irq mask, combinational read mux.
module xbutton_resp
  import xbutton_resp_pkg::*;
#(
  parameter int unsigned N_SW    = 8,
  parameter int unsigned N_BTN   = 4,
  parameter int unsigned DEB_W   = 16,
  parameter int unsigned DEB_CNT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  xbutton_resp_if.slave    bus,
  input  logic [N_SW-1:0]  sw_in,
  input  logic [N_BTN-1:0] btn_in,
  output logic             irq
);

  logic [N_SW-1:0]   w_sw_lvl;
  logic [N_BTN-1:0]  w_btn_lvl;
  logic [N_BTN-1:0]  w_btn_rise;
  logic [N_BTN-1:0]  w_evt_clr;
  logic              w_wr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_unused_data;

  logic [N_BTN-1:0]  r_btn_prev;
  logic [N_BTN-1:0]  r_evt;
  logic [N_BTN-1:0]  r_mask;
  logic              r_irq;

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    xdebounce #(.DEB_W(DEB_W), .DEB_CNT(DEB_CNT)) u_deb (
      .clk (clk), .rst (rst), .in (sw_in[g]), .out (w_sw_lvl[g])
    );
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    xdebounce #(.DEB_W(DEB_W), .DEB_CNT(DEB_CNT)) u_deb (
      .clk (clk), .rst (rst), .in (btn_in[g]), .out (w_btn_lvl[g])
    );
  end

  assign w_wr          = bus.sel & bus.we;
  assign w_btn_rise    = w_btn_lvl & ~r_btn_prev;
  assign w_evt_clr     = (w_wr && (bus.addr == BTN_EVT_ADDR)) ? bus.data_in[N_BTN-1:0] : '0;
  assign w_unused_data = &{1'b0, bus.data_in};

  // A press landing on the same edge as a write-1-clear keeps its flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_prev <= '0;
      r_evt      <= '0;
      r_mask     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_btn_prev <= w_btn_lvl;
      r_evt      <= (r_evt & ~w_evt_clr) | w_btn_rise;
      if (w_wr && (bus.addr == BTN_MASK_ADDR)) begin
        r_mask <= bus.data_in[N_BTN-1:0];
      end
      r_irq <= |(r_evt & r_mask);
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (bus.sel && !bus.we) begin
      case (reg_addr_e'(bus.addr))
        SW_LVL_ADDR:   w_rd_data = DATA_W'(w_sw_lvl);
        BTN_LVL_ADDR:  w_rd_data = DATA_W'(w_btn_lvl);
        BTN_EVT_ADDR:  w_rd_data = DATA_W'(r_evt);
        BTN_MASK_ADDR: w_rd_data = DATA_W'(r_mask);
        default:       w_rd_data = '0;
      endcase
    end
  end

  assign bus.data_to_rd = w_rd_data;
  assign irq            = r_irq;

endmodule

// File: tb/tb_xbutton_resp.sv
// Directed and randomized bench for xbutton_resp against a sliding-window debounce model.
module tb_xbutton_resp;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic [3:0] btn;
  logic       irq;

  int n_checks;
  int n_pass;

  xbutton_resp_if bus ();

  xbutton_resp #(.N_SW(8), .N_BTN(4), .DEB_W(16), .DEB_CNT(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .sw_in  (sw),
    .btn_in (btn),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: raw samples per edge; a level flips once the last D synchronised samples all disagree with it.
  logic [7:0] h_sw  [0:D+1];
  logic [3:0] h_btn [0:D+1];
  logic [7:0] m_sw;
  logic [3:0] m_btn, m_prev, m_evt, m_mask;
  logic       m_irq;

  task automatic model_step();
    logic [7:0] n_sw;
    logic [3:0] n_btn, clr;
    bit         all;
    if (rst) begin
      for (int j = 0; j <= D + 1; j++) begin h_sw[j] = '0; h_btn[j] = '0; end
      m_sw = '0; m_btn = '0; m_prev = '0; m_evt = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      for (int j = D + 1; j > 0; j--) begin h_sw[j] = h_sw[j-1]; h_btn[j] = h_btn[j-1]; end
      h_sw[0] = sw; h_btn[0] = btn;
      n_sw = m_sw;
      for (int b = 0; b < 8; b++) begin
        all = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (h_sw[j][b] == m_sw[b]) all = 1'b0;
        if (all) n_sw[b] = ~m_sw[b];
      end
      n_btn = m_btn;
      for (int b = 0; b < 4; b++) begin
        all = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (h_btn[j][b] == m_btn[b]) all = 1'b0;
        if (all) n_btn[b] = ~m_btn[b];
      end
      clr   = (bus.sel && bus.we && bus.addr == 2'd2) ? bus.data_in[3:0] : 4'h0;
      m_irq = |(m_evt & m_mask);
      m_evt = (m_evt & ~clr) | (m_btn & ~m_prev);
      m_prev = m_btn;
      if (bus.sel && bus.we && bus.addr == 2'd3) m_mask = bus.data_in[3:0];
      m_sw  = n_sw;
      m_btn = n_btn;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_sw};
      2'd1:    return {28'h0, m_btn};
      2'd2:    return {28'h0, m_evt};
      default: return {28'h0, m_mask};
    endcase
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1 d = bus.data_to_rd;
    bus.sel = 1'b0;
  endtask

  task automatic check_regs();
    logic [31:0] d;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check($sformatf("rd%0d", a), d, m_read(2'(a)));
    end
    check("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = v;
    tick();
    bus.sel = 1'b0; bus.we = 1'b0; bus.data_in = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin tick(); check_regs(); end
  endtask

  initial begin
    logic [31:0] d;
    n_checks = 0; n_pass = 0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
    for (int j = 0; j <= D + 1; j++) begin h_sw[j] = '0; h_btn[j] = '0; end
    m_sw = '0; m_btn = '0; m_prev = '0; m_evt = '0; m_mask = '0; m_irq = 1'b0;

    // Reset with pins high, then levels appear 2+D cycles later.
    sw = 8'hFF; btn = 4'hF; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin rd(2'(a), d); check("rst_rd", d, 32'h0); end
    check("rst_irq", {31'h0, irq}, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick(); check_regs();
      if (i == 5) begin rd(2'd0, d); check("sw_early", d, 32'h0); end
      if (i == 6) begin
        rd(2'd0, d); check("sw_lvl", d, 32'hFF);
        rd(2'd1, d); check("btn_lvl", d, 32'hF);
      end
    end

    // Bounce on btn0: only the final clean rise counts.
    btn = 4'h0; sw = 8'($urandom);
    run(8);
    wr(2'd2, 32'hF);
    rd(2'd2, d); check("evt_clr", d, 32'h0);
    btn[0] = 1'b1; tick(); tick();
    btn[0] = 1'b0; tick();
    btn[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(); check_regs();
      if (i == 5) begin rd(2'd1, d); check("bounce_early", d, 32'h0); end
      if (i == 6) begin rd(2'd1, d); check("bounce_rise", d, 32'h1); end
    end
    rd(2'd2, d); check("bounce_evt", d, 32'h1);

    // Mask gating and irq latency.
    wr(2'd2, 32'hF);
    wr(2'd3, 32'h1);
    btn = 4'h5;
    run(8);
    rd(2'd2, d); check("evt_btn2", d, 32'h4);
    check("irq_masked", {31'h0, irq}, 32'h0);
    wr(2'd3, 32'h4);
    check("irq_lag", {31'h0, irq}, 32'h0);
    tick();
    check("irq_on", {31'h0, irq}, 32'h1);

    // Write-1-clear, and set winning against a simultaneous clear.
    btn = 4'h4; run(8);
    btn = 4'h5; run(8);
    rd(2'd2, d); check("evt_5", d, 32'h5);
    wr(2'd2, 32'h1);
    rd(2'd2, d); check("w1c", d, 32'h4);
    btn = 4'h1; run(8);
    btn = 4'h5;
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 2'd2; bus.data_in = 32'h4;
    for (int i = 0; i < 7; i++) tick();
    bus.sel = 1'b0; bus.we = 1'b0; bus.data_in = '0;
    rd(2'd2, d); check("set_wins", d, 32'h4);
    check_regs();

    // Read gating and read-only registers.
    for (int a = 0; a < 4; a++) begin
      bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'(a);
      #1 check("rd_nosel", bus.data_to_rd, 32'h0);
      bus.sel = 1'b1; bus.we = 1'b1;
      #1 check("rd_wr", bus.data_to_rd, 32'h0);
      bus.sel = 1'b0; bus.we = 1'b0;
    end
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    check_regs();
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d); check("mask_upper", d, 32'hF);
    wr(2'd3, 32'h4);

    // Random pin activity with short and long holds.
    for (int r = 0; r < 12; r++) begin
      sw  = 8'($urandom);
      btn = 4'($urandom);
      run(int'($urandom_range(1, 8)));
    end

    // Reset mid-debounce with all events pending.
    sw = 8'h00; btn = 4'h0; run(8);
    btn = 4'hF; run(8);
    rd(2'd2, d); check("evt_all", d, 32'hF);
    sw = 8'hA5;
    run(4);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int a = 0; a < 4; a++) begin rd(2'(a), d); check("mid_rst_rd", d, 32'h0); end
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    tick(); check_regs();
    rd(2'd0, d); check("no_old_deadline", d, 32'h0);
    run(5);
    rd(2'd0, d); check("sw_after_rst", d, 32'hA5);
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
